spatial_feed_sequencer: RTL and testbench

- Controller placed in front of spatial_encoder.
- Accepts one sample as a packed vector of per-channel 2-bit feature codes.
- Walks channels 0..num_channel-1 in order, reading the item and projection hypervectors from a shared synchronous ROM port.
- Selects the positive, negative or zero projection per channel and drives the encoder's din_valid/din_ready handshake until all channels of the sample are delivered.

---
 rtl/spatial_seq_pkg.sv | 27 ++
 rtl/spatial_projm_select.sv | 27 ++
 rtl/spatial_feed_sequencer.sv | 148 ++++++++++++++
 tb/tb_spatial_feed_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatial_seq_pkg.sv
// Shared types and constants for the spatial feed sequencer.
// HV_DIMENSION may be supplied by the build; otherwise a 64-bit default is used.
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

package spatial_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } seq_state_t;

  localparam logic [1:0] FEAT_ZERO = 2'b00;
  localparam logic [1:0] FEAT_POS  = 2'b01;
  localparam logic [1:0] FEAT_NEG  = 2'b10;
  localparam logic [1:0] FEAT_ILL  = 2'b11;

  localparam int HV_DIM_DEFAULT = `HV_DIMENSION;

  // Channel index width; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spatial_projm_select.sv
// Picks the positive, negative or zero projection for one feature code
// and flags the illegal code.
module spatial_projm_select
  import spatial_seq_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEFAULT
) (
  input  logic [1:0]        i_code,
  input  logic [HV_DIM-1:0] i_pos,
  input  logic [HV_DIM-1:0] i_neg,
  output logic [HV_DIM-1:0] o_projm,
  output logic              o_illegal
);

  // Code decode; zero and illegal codes both yield an all-zero projection.
  always_comb begin
    o_projm   = '0;
    o_illegal = 1'b0;
    case (i_code)
      FEAT_POS: o_projm   = i_pos;
      FEAT_NEG: o_projm   = i_neg;
      FEAT_ILL: o_illegal = 1'b1;
      default:  o_projm   = '0;
    endcase
  end

endmodule

// File: rtl/spatial_feed_sequencer.sv
// Feeds one sample, channel by channel, from the shared ROM into spatial_encoder.
// Optional build macro SEQ_PERF_EN adds saturating stall_cnt / sample_cnt outputs.
//
// state | meaning
// IDLE  | waiting for a sample, fin_ready high
// FETCH | ROM strobe for channel ch
// SEND  | ROM data presented to the encoder until din handshake
module spatial_feed_sequencer
  import spatial_seq_pkg::*;
#(
  parameter int num_channel = 32,
  parameter int HV_DIM      = HV_DIM_DEFAULT,
  parameter int CH_W        = ch_width(num_channel)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fin_valid,
  output logic                     fin_ready,
  input  logic [2*num_channel-1:0] features,
  output logic                     rom_rd_en,
  output logic [CH_W-1:0]          rom_addr,
  input  logic [HV_DIM-1:0]        im_rdata,
  input  logic [HV_DIM-1:0]        projm_pos_rdata,
  input  logic [HV_DIM-1:0]        projm_neg_rdata,
  output logic                     din_valid,
  input  logic                     din_ready,
  output logic [HV_DIM-1:0]        im,
  output logic [HV_DIM-1:0]        projm,
  output logic                     busy,
  output logic                     sample_done,
`ifdef SEQ_PERF_EN
  output logic [31:0]              stall_cnt,
  output logic [31:0]              sample_cnt,
`endif
  output logic                     code_err
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(num_channel - 1);

  seq_state_t               r_state;
  logic [CH_W-1:0]          r_ch;
  logic [2*num_channel-1:0] r_features;
  logic                     r_rom_rd_en;
  logic                     r_din_valid;
  logic                     r_busy;
  logic                     r_sample_done;
  logic                     r_code_err;

  logic [2*num_channel-1:0] w_shifted;
  logic [1:0]               w_code;
  logic [HV_DIM-1:0]        w_projm;
  logic                     w_illegal;
  logic                     w_handshake;

  assign w_shifted   = r_features >> {r_ch, 1'b0};
  assign w_code      = w_shifted[1:0];
  assign w_handshake = r_din_valid & din_ready;

  spatial_projm_select #(.HV_DIM(HV_DIM)) u_sel (
    .i_code    (w_code),
    .i_pos     (projm_pos_rdata),
    .i_neg     (projm_neg_rdata),
    .o_projm   (w_projm),
    .o_illegal (w_illegal)
  );

  // Sequencing FSM: one FETCH/SEND pair per channel, registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_ch          <= '0;
      r_features    <= '0;
      r_rom_rd_en   <= 1'b0;
      r_din_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_sample_done <= 1'b0;
      r_code_err    <= 1'b0;
    end else begin
      r_sample_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fin_valid) begin
            r_features  <= features;
            r_ch        <= '0;
            r_rom_rd_en <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          // ROM data lands this edge; the code for ch is already decodable.
          r_rom_rd_en <= 1'b0;
          r_din_valid <= 1'b1;
          if (w_illegal) r_code_err <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (w_handshake) begin
            r_din_valid <= 1'b0;
            if (r_ch == LAST_CH) begin
              r_busy        <= 1'b0;
              r_sample_done <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_ch        <= r_ch + 1'b1;
              r_rom_rd_en <= 1'b1;
              r_state     <= FETCH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_sample_cnt;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_sample_cnt <= '0;
    end else begin
      if (r_din_valid && !din_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (r_sample_done && (r_sample_cnt != '1))
        r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign sample_cnt = r_sample_cnt;
`endif

  // Data path is gated so the encoder sees zeros whenever din_valid is low.
  assign im          = r_din_valid ? im_rdata : '0;
  assign projm       = r_din_valid ? w_projm  : '0;
  assign fin_ready   = (r_state == IDLE);
  assign rom_rd_en   = r_rom_rd_en;
  assign rom_addr    = r_ch;
  assign din_valid   = r_din_valid;
  assign busy        = r_busy;
  assign sample_done = r_sample_done;
  assign code_err    = r_code_err;

endmodule

// File: tb/tb_spatial_feed_sequencer.sv
// Bench for spatial_feed_sequencer (num_channel=4). A queue of expected
// channel deliveries is built from each accepted feature vector and checked
// against every encoder handshake; literal checks pin the model.
module tb_spatial_feed_sequencer;
  localparam int NCH = 4;
  localparam int HVD = 16;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fin_valid = 1'b0;
  logic           din_ready = 1'b1;
  logic [2*NCH-1:0] features = '0;
  logic           fin_ready, rom_rd_en, din_valid, busy, sample_done, code_err;
  logic [CHW-1:0] rom_addr;
  logic [HVD-1:0] im_rdata = '0, pos_rdata = '0, neg_rdata = '0, im, projm;
`ifdef SEQ_PERF_EN
  logic [31:0] stall_cnt, sample_cnt;
`endif

  spatial_feed_sequencer #(.num_channel(NCH), .HV_DIM(HVD)) dut (
    .clk(clk), .rst(rst), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .features(features), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
    .im_rdata(im_rdata), .projm_pos_rdata(pos_rdata), .projm_neg_rdata(neg_rdata),
    .din_valid(din_valid), .din_ready(din_ready), .im(im), .projm(projm),
    .busy(busy), .sample_done(sample_done),
`ifdef SEQ_PERF_EN
    .stall_cnt(stall_cnt), .sample_cnt(sample_cnt),
`endif
    .code_err(code_err)
  );

  always #5 clk = ~clk;

  // ROM contents: item A00k, positive B00k, negative C00k.
  logic [HVD-1:0] im_mem [NCH];
  logic [HVD-1:0] pos_mem[NCH];
  logic [HVD-1:0] neg_mem[NCH];
  initial for (int k = 0; k < NCH; k++) begin
    im_mem[k]  = 16'hA000 + 16'(k);
    pos_mem[k] = 16'hB000 + 16'(k);
    neg_mem[k] = 16'hC000 + 16'(k);
  end

  always @(posedge clk) if (rom_rd_en) begin
    im_rdata  <= im_mem[rom_addr];
    pos_rdata <= pos_mem[rom_addr];
    neg_rdata <= neg_mem[rom_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int             ch;
    logic [HVD-1:0] im;
    logic [HVD-1:0] pj;
    bit             ill;
  } exp_t;

  exp_t           q[$];
  exp_t           e_cur;
  logic [1:0]     c_tmp;
  logic [HVD-1:0] pj_tmp;
  logic [HVD-1:0] hs_pj[$];
  int             hs_addr[$];
  int             ncyc = 0, acc_ncyc = 0, first_dv_ncyc = -1, done_ncyc = -1;
  int             n_hs = 0, n_done = 0, strobes = 0;
  bit             exp_done = 0, exp_err = 0, prev_stall = 0;
  logic [HVD-1:0] prev_im, prev_pj;

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      q.delete();
      exp_done = 0; exp_err = 0; prev_stall = 0; strobes = 0;
    end else begin
      check("sample_done", sample_done, exp_done);
      if (sample_done) begin n_done++; done_ncyc = ncyc; end
      exp_done = 0;
      check("fin_ready", fin_ready, q.size() == 0);
      check("busy", busy, q.size() != 0);
      if (q.size() == 0) check("code_err_idle", code_err, exp_err);
      if (rom_rd_en) strobes++;
      if (prev_stall) begin
        check("im_stable", im, prev_im);
        check("projm_stable", projm, prev_pj);
      end
      if (din_valid) begin
        if (first_dv_ncyc < 0) first_dv_ncyc = ncyc;
        check("no_strobe_in_send", rom_rd_en, 0);
        if (din_ready) begin
          if (q.size() == 0) begin
            check("unexpected_handshake", 1, 0);
          end else begin
            e_cur = q.pop_front();
            check("hs_addr", rom_addr, e_cur.ch);
            check("hs_im", im, e_cur.im);
            check("hs_projm", projm, e_cur.pj);
            check("hs_strobes", strobes, e_cur.ch + 1);
            if (e_cur.ill) exp_err = 1;
            check("hs_code_err", code_err, exp_err);
            hs_pj.push_back(projm);
            hs_addr.push_back(int'(rom_addr));
            n_hs++;
            if (q.size() == 0) exp_done = 1;
          end
        end
      end else begin
        check("im_zero", im, 0);
        check("projm_zero", projm, 0);
      end
      prev_stall = din_valid && !din_ready;
      prev_im = im;
      prev_pj = projm;
      if (fin_valid && fin_ready) begin
        acc_ncyc = ncyc; strobes = 0; first_dv_ncyc = -1;
        for (int k = 0; k < NCH; k++) begin
          c_tmp  = features[2*k +: 2];
          pj_tmp = (c_tmp == 2'b01) ? pos_mem[k] : (c_tmp == 2'b10) ? neg_mem[k] : '0;
          q.push_back('{ch: k, im: im_mem[k], pj: pj_tmp, ill: (c_tmp == 2'b11)});
        end
      end
    end
  end

  task automatic send_sample(input logic [2*NCH-1:0] f, input bit hold);
    bit ok;
    ok = 0;
    features  = f;
    fin_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); ok = fin_ready;
      @(posedge clk); #2;
    end
    if (!ok) check("fin_accept_timeout", 0, 1);
    if (!hold) fin_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (q.size() == 0) && fin_ready;
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  task automatic wait_send_ch2();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #2;
      ok = din_valid && (rom_addr == 2'd2);
    end
    if (!ok) check("ch2_timeout", 0, 1);
  endtask

  int b, hs0, d0;
  bit stop;
`ifdef SEQ_PERF_EN
  logic [31:0] perf0;
`endif

  initial begin
    // Reset values
    repeat (3) @(posedge clk); #2;
    check("rst_din_valid", din_valid, 0);
    check("rst_rom_rd_en", rom_rd_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_sample_done", sample_done, 0);
    check("rst_code_err", code_err, 0);
    check("rst_fin_ready", fin_ready, 1);
    check("rst_im", im, 0);
    check("rst_projm", projm, 0);
    repeat (2) @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // Basic sample
    b = hs_pj.size();
    send_sample(8'b00_10_01_01, 0);
    wait_idle();
    check("basic_hs_count", hs_pj.size() - b, 4);
    check("basic_pj0", hs_pj[b],   16'hB000);
    check("basic_pj1", hs_pj[b+1], 16'hB001);
    check("basic_pj2", hs_pj[b+2], 16'hC002);
    check("basic_pj3", hs_pj[b+3], 16'h0000);
    check("basic_first_dv_latency", first_dv_ncyc - acc_ncyc, 2);
    check("basic_done_cycle", done_ncyc - acc_ncyc, 9);

    // Backpressure on channel 2
`ifdef SEQ_PERF_EN
    perf0 = stall_cnt;
`endif
    hs0 = n_hs;
    send_sample(8'b01_01_10_01, 0);
    wait_send_ch2();
    din_ready = 1'b0;
    repeat (7) @(posedge clk);
    #2 din_ready = 1'b1;
    wait_idle();
    check("bp_hs_count", n_hs - hs0, 4);
    check("bp_strobes_total", strobes, 4);
`ifdef SEQ_PERF_EN
    check("bp_stall_cnt", stall_cnt - perf0, 7);
`endif

    // Illegal code on channel 1
    b = hs_pj.size();
    send_sample(8'b01_10_11_01, 0);
    wait_idle();
    check("ill_pj1", hs_pj[b+1], 0);
    check("ill_code_err", code_err, 1);
    send_sample(8'b01_01_01_01, 0);
    wait_idle();
    check("ill_code_err_sticky", code_err, 1);

    // Back-to-back samples with random din_ready
    hs0 = n_hs; d0 = n_done; stop = 0;
`ifdef SEQ_PERF_EN
    perf0 = sample_cnt;
`endif
    fork
      begin
        send_sample(8'b10_01_10_01, 1);
        send_sample(8'b01_10_00_10, 1);
        send_sample(8'b00_00_01_10, 0);
        wait_idle();
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #2;
          din_ready = 1'($urandom_range(0, 1));
        end
        din_ready = 1'b1;
      end
    join
    check("b2b_hs_count", n_hs - hs0, 12);
    check("b2b_done_count", n_done - d0, 3);
`ifdef SEQ_PERF_EN
    check("b2b_sample_cnt", sample_cnt - perf0, 3);
`endif

    // Reset mid-sample during channel 2
    send_sample(8'b01_01_01_01, 0);
    wait_send_ch2();
    #1 rst = 1'b0;
    #1;
    check("mrst_din_valid", din_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_im", im, 0);
    check("mrst_code_err", code_err, 0);
    d0 = n_done;
    repeat (3) @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk); #2;
    check("mrst_no_done", n_done - d0, 0);
    b = hs_pj.size();
    send_sample(8'b10_10_10_10, 0);
    wait_idle();
    check("mrst_restart_addr", hs_addr[b], 0);
    check("mrst_restart_pj", hs_pj[b], 16'hC000);
    check("mrst_hs_count", hs_pj.size() - b, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
